serial_ctrl: RTL and testbench

//  Synchronous full-duplex serial shifter, SPI-master style, with a gated bit clock.
//  - Sends parallel words MSB- or LSB-first on out_serial.
//  - Simultaneously assembles in_serial into out_parallel.
//  - out_next_word requests the next word, giving back-to-back streaming.
//  - Sits between a byte-producing FSM and an off-chip serial pin; loopback (out_serial->in_serial) is legal.

---
 rtl/serial_pkg.sv | 20 ++
 rtl/serial_ctrl_clkgen.sv | 48 ++++
 rtl/serial_ctrl.sv | 134 +++++++++++++
 tb/tb_serial_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : serial_pkg                                                      |
// | Purpose  : Shared types and helpers for the serial_ctrl shifter            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package serial_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        TX   = 1'b1
    } t_serial_state;

    // Counter width that stays legal (>=1) even for a range of a single value.
    function automatic int f_cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_ctrl_clkgen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : serial_ctrl_clkgen                                              |
// | Purpose  : Half-period divider emitting alternating sample/shift strobes   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module serial_ctrl_clkgen
    import serial_pkg::*;
#(
    parameter int HALF_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    output logic o_sample_tick,
    output logic o_shift_tick
);

    localparam int                 c_CNT_W    = f_cnt_width(HALF_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(HALF_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_phase;
    logic               w_tick;

    // Holding restart parks the divider so the first strobe lands HALF_DIV cycles after release.
    assign w_tick = !i_restart && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (i_restart) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_tick) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign o_sample_tick = w_tick & ~r_phase;
    assign o_shift_tick  = w_tick &  r_phase;

endmodule
`default_nettype wire

// File: rtl/serial_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : serial_ctrl                                                     |
// | Purpose  : Full-duplex SPI-master style shifter with gated bit clock       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module serial_ctrl
    import serial_pkg::*;
#(
    parameter int BITS                = 8,
    parameter bit LOWBIT_FIRST        = 1'b1,
    parameter int MAIN_CLK_HZ         = 50_000_000,
    parameter int SERIAL_CLK_HZ       = 10_000,
    parameter bit SERIAL_CLK_INACTIVE = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BITS-1:0] in_parallel,
    input  logic            in_enable,
    output logic            out_serial,
    output logic            out_next_word,
    output logic            out_ready,
    output logic            out_clk,
    input  logic            in_serial,
    output logic [BITS-1:0] out_parallel
);

    localparam int                 c_DIV      = MAIN_CLK_HZ / SERIAL_CLK_HZ;
    localparam int                 c_CTR_W    = f_cnt_width(BITS);
    localparam logic [c_CTR_W-1:0] c_LAST_BIT = c_CTR_W'(BITS - 1);

    t_serial_state      r_state, w_state_next;
    logic [BITS-1:0]    r_tx, w_tx_next, w_tx_shifted;
    logic [BITS-1:0]    r_rx, w_rx_next, w_rx_shifted;
    logic [BITS-1:0]    r_par, w_par_next;
    logic [c_CTR_W-1:0] r_ctr, w_ctr_next;
    logic               r_sclk, w_sclk_next;
    logic               w_sample_tick;
    logic               w_shift_tick;
    logic               w_restart;

    assign w_restart = (r_state == IDLE);

    serial_ctrl_clkgen #(
        .HALF_DIV (c_DIV / 2)
    ) u_clkgen (
        .clk           (clk),
        .rst           (rst),
        .i_restart     (w_restart),
        .o_sample_tick (w_sample_tick),
        .o_shift_tick  (w_shift_tick)
    );

    // Received bits land in the same position they were sent from, so loopback is an identity.
    assign w_tx_shifted = LOWBIT_FIRST ? {1'b0, r_tx[BITS-1:1]}     : {r_tx[BITS-2:0], 1'b0};
    assign w_rx_shifted = LOWBIT_FIRST ? {in_serial, r_rx[BITS-1:1]} : {r_rx[BITS-2:0], in_serial};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_tx_next    = r_tx;
        w_rx_next    = r_rx;
        w_ctr_next   = r_ctr;
        w_par_next   = r_par;
        w_sclk_next  = r_sclk;
        case (r_state)
            IDLE: begin
                w_sclk_next = SERIAL_CLK_INACTIVE;
                if (in_enable) begin
                    w_state_next = TX;
                    w_tx_next    = in_parallel;
                    w_ctr_next   = '0;
                end
            end
            TX: begin
                if (w_sample_tick) begin
                    w_sclk_next = ~SERIAL_CLK_INACTIVE;
                    w_rx_next   = w_rx_shifted;
                end
                if (w_shift_tick) begin
                    w_sclk_next = SERIAL_CLK_INACTIVE;
                    if (r_ctr == c_LAST_BIT) begin
                        // Word boundary: the divider keeps running, so a follow-on word has no gap.
                        w_par_next = r_rx;
                        w_ctr_next = '0;
                        if (in_enable) begin
                            w_tx_next = in_parallel;
                        end else begin
                            w_state_next = IDLE;
                            w_tx_next    = '0;
                        end
                    end else begin
                        w_ctr_next = r_ctr + 1'b1;
                        w_tx_next  = w_tx_shifted;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx   <= '0;
            r_rx   <= '0;
            r_par  <= '0;
            r_ctr  <= '0;
            r_sclk <= SERIAL_CLK_INACTIVE;
        end else begin
            r_tx   <= w_tx_next;
            r_rx   <= w_rx_next;
            r_par  <= w_par_next;
            r_ctr  <= w_ctr_next;
            r_sclk <= w_sclk_next;
        end
    end

    assign out_serial    = LOWBIT_FIRST ? r_tx[0] : r_tx[BITS-1];
    assign out_next_word = (r_state == TX) && (r_ctr == c_LAST_BIT);
    assign out_ready     = (r_state == IDLE);
    assign out_clk       = r_sclk;
    assign out_parallel  = r_par;

endmodule
`default_nettype wire

// File: tb/tb_serial_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_serial_ctrl                                                  |
// | Purpose  : Scoreboard bench for serial_ctrl in loopback, three variants    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_serial_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] a_pin, b_pin, c_pin;
    logic       a_en, b_en, c_en;
    logic       a_ser, b_ser, c_ser;
    logic       a_nw, b_nw, c_nw;
    logic       a_rdy, b_rdy, c_rdy;
    logic       a_sclk, b_sclk, c_sclk;
    logic [7:0] a_pout, b_pout, c_pout;

    logic [7:0] sb_a[$];
    logic [7:0] sb_b[$];
    logic [7:0] sb_c[$];

    int n_cmp = 0;
    int n_bad = 0;

    // A: LSB first, idle low. B: MSB first, idle low. C: LSB first, idle high. DIV = 4.
    serial_ctrl #(.BITS(8), .LOWBIT_FIRST(1'b1), .MAIN_CLK_HZ(40_000), .SERIAL_CLK_HZ(10_000),
                  .SERIAL_CLK_INACTIVE(1'b0)) u_dut_a (
        .clk(clk), .rst(rst), .in_parallel(a_pin), .in_enable(a_en), .out_serial(a_ser),
        .out_next_word(a_nw), .out_ready(a_rdy), .out_clk(a_sclk), .in_serial(a_ser),
        .out_parallel(a_pout));

    serial_ctrl #(.BITS(8), .LOWBIT_FIRST(1'b0), .MAIN_CLK_HZ(40_000), .SERIAL_CLK_HZ(10_000),
                  .SERIAL_CLK_INACTIVE(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .in_parallel(b_pin), .in_enable(b_en), .out_serial(b_ser),
        .out_next_word(b_nw), .out_ready(b_rdy), .out_clk(b_sclk), .in_serial(b_ser),
        .out_parallel(b_pout));

    serial_ctrl #(.BITS(8), .LOWBIT_FIRST(1'b1), .MAIN_CLK_HZ(40_000), .SERIAL_CLK_HZ(10_000),
                  .SERIAL_CLK_INACTIVE(1'b1)) u_dut_c (
        .clk(clk), .rst(rst), .in_parallel(c_pin), .in_enable(c_en), .out_serial(c_ser),
        .out_next_word(c_nw), .out_ready(c_rdy), .out_clk(c_sclk), .in_serial(c_ser),
        .out_parallel(c_pout));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        logic [4:0] got_a, got_b, got_c;
        got_a = {a_rdy, a_sclk, a_ser, a_nw, |a_pout};
        got_b = {b_rdy, b_sclk, b_ser, b_nw, |b_pout};
        got_c = {c_rdy, c_sclk, c_ser, c_nw, |c_pout};
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (got_a[i] !== (i == 4)) begin
                n_bad++; $display("FAIL reset_a bit%0d: got %b want %b", i, got_a[i], (i == 4));
            end
            n_cmp++;
            if (got_b[i] !== (i == 4)) begin
                n_bad++; $display("FAIL reset_b bit%0d: got %b want %b", i, got_b[i], (i == 4));
            end
            n_cmp++;
            if (got_c[i] !== (i == 4 || i == 3)) begin
                n_bad++; $display("FAIL reset_c bit%0d: got %b want %b", i, got_c[i], (i == 4 || i == 3));
            end
        end
    endtask

    task automatic test_stream(input bit glitch);
        logic [7:0] words[4];
        logic [7:0] exp;
        int   idx, falls, cyc, toggles;
        logic prev_nw, prev_clk, pend;
        words = '{8'hff, 8'h11, 8'h01, 8'h10};
        @(negedge clk);
        a_pin = words[0]; a_en = 1'b1; sb_a.push_back(words[0]);
        idx = 1; falls = 0; cyc = 0; toggles = 0; pend = 1'b0;
        prev_nw = a_nw; prev_clk = a_sclk;
        while (falls < 4 && cyc < 200) begin
            @(negedge clk); cyc++;
            if (pend) begin a_en = 1'b1; pend = 1'b0; end
            if (a_sclk !== prev_clk) toggles++;
            prev_clk = a_sclk;
            if (a_nw === 1'b1 && prev_nw === 1'b0) begin
                if (idx < 4) begin
                    a_pin = words[idx]; sb_a.push_back(words[idx]); idx++;
                    if (glitch) begin a_en = 1'b0; pend = 1'b1; end
                end else begin
                    a_en = 1'b0;
                end
            end
            if (a_nw === 1'b0 && prev_nw === 1'b1) begin
                exp = (sb_a.size() > 0) ? sb_a.pop_front() : 8'hxx;
                n_cmp++;
                if (a_pout !== exp) begin
                    n_bad++; $display("FAIL stream%0d word%0d: got %h want %h", glitch, falls, a_pout, exp);
                end
                n_cmp++;
                if (cyc !== 32 * (falls + 1) + 1) begin
                    n_bad++; $display("FAIL stream%0d timing%0d: got %0d want %0d", glitch, falls, cyc, 32 * (falls + 1) + 1);
                end
                if (falls < 3) begin
                    n_cmp++;
                    if (a_rdy !== 1'b0) begin
                        n_bad++; $display("FAIL stream%0d busy%0d: got %b want 0", glitch, falls, a_rdy);
                    end
                end
                falls++;
            end
            prev_nw = a_nw;
        end
        n_cmp++;
        if (falls != 4) begin
            n_bad++; $display("FAIL stream%0d timeout: got %0d words want 4", glitch, falls);
        end
        n_cmp++;
        if (toggles != 64) begin
            n_bad++; $display("FAIL stream%0d clk_edges: got %0d want 64", glitch, toggles);
        end
        a_en = 1'b0;
    endtask

    task automatic test_stop();
        logic [7:0] exp;
        int   cyc;
        logic prev_nw, seen;
        @(negedge clk);
        a_pin = 8'h3c; a_en = 1'b1; sb_a.push_back(8'h3c);
        cyc = 0; seen = 1'b0; prev_nw = a_nw;
        while (!seen && cyc < 60) begin
            @(negedge clk); cyc++;
            a_en = 1'b0;
            if (a_nw === 1'b0 && prev_nw === 1'b1) seen = 1'b1;
            prev_nw = a_nw;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++; $display("FAIL stop timeout: got no word end want one");
        end
        exp = (sb_a.size() > 0) ? sb_a.pop_front() : 8'hxx;
        n_cmp++;
        if (a_pout !== exp) begin
            n_bad++; $display("FAIL stop word: got %h want %h", a_pout, exp);
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if ({a_rdy, a_sclk, a_ser} !== 3'b100) begin
                n_bad++; $display("FAIL stop idle%0d: got %b want 100", i, {a_rdy, a_sclk, a_ser});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_bit_order();
        logic [7:0] exp;
        int   cyc, k;
        logic pa, pb, fa, fb;
        @(negedge clk);
        a_pin = 8'h80; a_en = 1'b1; sb_a.push_back(8'h80);
        b_pin = 8'h80; b_en = 1'b1; sb_b.push_back(8'h80);
        cyc = 0; fa = 1'b0; fb = 1'b0; pa = a_nw; pb = b_nw;
        while (!(fa && fb) && cyc < 60) begin
            @(negedge clk); cyc++;
            a_en = 1'b0; b_en = 1'b0;
            if (cyc % 4 == 2 && cyc <= 30) begin
                k = (cyc - 2) / 4;
                n_cmp++;
                if (a_ser !== (k == 7)) begin
                    n_bad++; $display("FAIL lsb_first bit%0d: got %b want %b", k, a_ser, (k == 7));
                end
                n_cmp++;
                if (b_ser !== (k == 0)) begin
                    n_bad++; $display("FAIL msb_first bit%0d: got %b want %b", k, b_ser, (k == 0));
                end
            end
            if (a_nw === 1'b0 && pa === 1'b1) begin
                fa = 1'b1;
                exp = (sb_a.size() > 0) ? sb_a.pop_front() : 8'hxx;
                n_cmp++;
                if (a_pout !== exp) begin
                    n_bad++; $display("FAIL lsb_first word: got %h want %h", a_pout, exp);
                end
            end
            if (b_nw === 1'b0 && pb === 1'b1) begin
                fb = 1'b1;
                exp = (sb_b.size() > 0) ? sb_b.pop_front() : 8'hxx;
                n_cmp++;
                if (b_pout !== exp) begin
                    n_bad++; $display("FAIL msb_first word: got %h want %h", b_pout, exp);
                end
            end
            pa = a_nw; pb = b_nw;
        end
        n_cmp++;
        if (!(fa && fb)) begin
            n_bad++; $display("FAIL bit_order timeout: got ends %b%b want 11", fa, fb);
        end
    endtask

    task automatic test_inactive_high();
        logic [7:0] exp;
        int   cyc;
        logic prev_nw, seen;
        @(negedge clk);
        n_cmp++;
        if (c_sclk !== 1'b1) begin
            n_bad++; $display("FAIL inact idle_clk: got %b want 1", c_sclk);
        end
        c_pin = 8'ha5; c_en = 1'b1; sb_c.push_back(8'ha5);
        cyc = 0; seen = 1'b0; prev_nw = c_nw;
        while (!seen && cyc < 60) begin
            @(negedge clk); cyc++;
            c_en = 1'b0;
            if (cyc == 2) begin
                n_cmp++;
                if (c_sclk !== 1'b1) begin
                    n_bad++; $display("FAIL inact pre_edge: got %b want 1", c_sclk);
                end
            end
            if (cyc == 3) begin
                n_cmp++;
                if (c_sclk !== 1'b0) begin
                    n_bad++; $display("FAIL inact first_edge: got %b want 0", c_sclk);
                end
            end
            if (c_nw === 1'b0 && prev_nw === 1'b1) seen = 1'b1;
            prev_nw = c_nw;
        end
        exp = (sb_c.size() > 0) ? sb_c.pop_front() : 8'hxx;
        n_cmp++;
        if (!seen || c_pout !== exp) begin
            n_bad++; $display("FAIL inact word: got %h want %h", c_pout, exp);
        end
        n_cmp++;
        if ({c_rdy, c_sclk} !== 2'b11) begin
            n_bad++; $display("FAIL inact end_idle: got %b want 11", {c_rdy, c_sclk});
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp;
        int   cyc;
        logic prev_nw, seen;
        @(negedge clk);
        a_pin = 8'hff; a_en = 1'b1;
        @(negedge clk);
        a_en = 1'b0;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({a_rdy, a_sclk, a_ser, a_nw} !== 4'b1000) begin
            n_bad++; $display("FAIL rst_mid flags: got %b want 1000", {a_rdy, a_sclk, a_ser, a_nw});
        end
        n_cmp++;
        if (a_pout !== 8'h00) begin
            n_bad++; $display("FAIL rst_mid pout: got %h want 00", a_pout);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        a_pin = 8'ha5; a_en = 1'b1; sb_a.push_back(8'ha5);
        cyc = 0; seen = 1'b0; prev_nw = a_nw;
        while (!seen && cyc < 60) begin
            @(negedge clk); cyc++;
            a_en = 1'b0;
            if (a_nw === 1'b1 && prev_nw === 1'b0) begin
                n_cmp++;
                if (a_pout !== 8'h00) begin
                    n_bad++; $display("FAIL rst_mid partial: got %h want 00", a_pout);
                end
            end
            if (a_nw === 1'b0 && prev_nw === 1'b1) seen = 1'b1;
            prev_nw = a_nw;
        end
        exp = (sb_a.size() > 0) ? sb_a.pop_front() : 8'hxx;
        n_cmp++;
        if (!seen || a_pout !== exp) begin
            n_bad++; $display("FAIL rst_mid word: got %h want %h", a_pout, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        a_pin = '0; b_pin = '0; c_pin = '0;
        a_en = 1'b0; b_en = 1'b0; c_en = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_stream(1'b0);
        test_stream(1'b1);
        test_stop();
        test_bit_order();
        test_inactive_high();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
